alu_issue_arb: RTL and testbench

- Two-requester arbiter and sequencer for the shared 16-bit ALU datapath.
- Accepts operation requests over valid/ready, drives ALU operands and opcode from holding registers, captures the result, and returns it over a valid/ready response channel.
- Owns the architectural ZVN flag register; updates it using the ALU's per-flag enables.
- Sits between the execute stage (requester 0) and the address/auxiliary path (requester 1) and the combinational ALU.

---
 rtl/alu_issue_arb_pkg.sv | 25 ++
 rtl/alu_issue_arb_flag_reg.sv | 33 +++
 rtl/alu_issue_arb.sv | 175 +++++++++++++++++
 tb/tb_alu_issue_arb.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arb_pkg.sv
// Shared types and constants for the ALU issue arbiter slice.
// State encoding, ZVN flag bit positions and the ALU opcodes used by benches.
package alu_issue_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 4;
  localparam int FLAG_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Flag bit positions inside the ZVN vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // ALU opcodes.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;

endpackage

// File: rtl/alu_issue_arb_flag_reg.sv
// Architectural ZVN flag register with per-bit write enables.
// Only bits whose enable is set take the new value on a write; the rest hold.
module alu_flag_reg #(
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [FLAG_W-1:0] en,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [FLAG_W-1:0] flags_q
);

  logic [FLAG_W-1:0] flags_d;

  // Merge enabled bits of the incoming flags into the held value.
  always_comb begin
    flags_d = flags_q;
    if (wr) begin
      flags_d = (flags_q & ~en) | (flags_in & en);
    end
  end

  // Flag storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: rtl/alu_issue_arb.sv
// Two-requester issue arbiter and sequencer for the shared combinational ALU.
// Flow: IDLE (accept one request) -> EXEC (ALU evaluates holding regs) -> RESP
// (result held until consumed). Optional macro ALU_ISSUE_ARB_RR_EN selects
// round-robin arbitration; without it requester 0 has fixed priority.
//
// Handshake rule for all channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender holds valid and payload stable
// until that edge; ready may depend combinationally on valid.
module alu_issue_arb
  import alu_issue_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_setflags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_setflags,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] alu_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] flags_q,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              id_q, id_d, setf_q, setf_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              grant0, grant1, accept, accept_id;

`ifdef ALU_ISSUE_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Round-robin pick: on contention the requester that did not win last time goes.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end
  end

  // Remember who won the most recent accept.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = accept_id;
  end

  // Last-grant register; resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: requester 0 always wins on contention.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  // FSM outputs: ready only in IDLE and never during reset; ALU fed from holding regs.
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && !rst && grant0;
    req1_ready = (state_q == ST_IDLE) && !rst && grant1;
    accept     = req0_ready | req1_ready;
    accept_id  = req1_ready;
    alu_in1    = a_q;
    alu_in2    = b_q;
    alu_op     = op_q;
    rsp_valid  = rsp_valid_q;
    rsp_id     = rsp_id_q;
    rsp_data   = rsp_data_q;
    dbg_state  = state_q;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding registers load the winner's payload on accept.
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    id_d   = id_q;
    setf_d = setf_q;
    if (accept) begin
      op_d   = accept_id ? req1_op       : req0_op;
      a_d    = accept_id ? req1_a        : req0_a;
      b_d    = accept_id ? req1_b        : req0_b;
      setf_d = accept_id ? req1_setflags : req0_setflags;
      id_d   = accept_id;
    end
  end

  // Response capture at the end of EXEC, release when the consumer takes it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (state_q == ST_EXEC) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = id_q;
      rsp_data_d  = alu_out;
    end else if (state_q == ST_RESP && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State, holding and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      setf_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      setf_q      <= setf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Flags are written only while the ALU is evaluating a flag-setting request.
  alu_flag_reg #(.FLAG_W(FLAG_W)) u_flag_reg (
    .clk      (clk),
    .rst      (rst),
    .wr       ((state_q == ST_EXEC) && setf_q),
    .en       (alu_en),
    .flags_in (alu_flags),
    .flags_q  (flags_q)
  );

endmodule

// File: tb/tb_alu_issue_arb.sv
// Self-checking bench for alu_issue_arb. Provides a behavioural ALU, a
// transaction-level expected queue and flag model, and directed plus random tests.
module tb_alu_issue_arb;
  import alu_issue_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_setflags = 1'b0, req1_setflags = 1'b0;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic [2:0]  alu_flags, alu_en;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  flags_q;
  state_t      dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  logic [2:0]  mdl_flags = 3'b000;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  alu_issue_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setflags(req0_setflags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_setflags(req1_setflags),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_en(alu_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .flags_q(flags_q), .dbg_state(dbg_state)
  );

  // ALU behaviour packed as {en[2:0], zvn[2:0], result[15:0]}.
  function automatic logic [21:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    case (op)
      OP_ADD: begin
        r = a + b;
        v = (a[15] == b[15]) && (r[15] != a[15]);
        return {3'b111, (r == 16'h0), v, r[15], r};
      end
      OP_SUB: begin
        r = a - b;
        v = (a[15] != b[15]) && (r[15] != a[15]);
        return {3'b111, (r == 16'h0), v, r[15], r};
      end
      OP_XOR: begin
        r = a ^ b;
        return {3'b100, (r == 16'h0), 1'b0, r[15], r};
      end
      default: return {3'b000, 3'b000, a};
    endcase
  endfunction

  logic [21:0] alu_res;
  always_comb begin
    alu_res   = alu_fn(alu_op, alu_in1, alu_in2);
    alu_out   = alu_res[15:0];
    alu_flags = alu_res[18:16];
    alu_en    = alu_res[21:19];
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; presents a request and returns at the falling edge after acceptance.
  task automatic send(input bit id, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input bit sf, output bit ok);
    logic [21:0] r;
    ok = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_setflags = sf;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_setflags = sf;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (ok) begin
      r = alu_fn(op, a, b);
      exp_q.push_back({id, r[15:0]});
      if (sf) mdl_flags = (mdl_flags & ~r[21:19]) | (r[18:16] & r[21:19]);
    end
  endtask

  // Waits (bounded) for rsp_valid and returns the observed response.
  task automatic collect(output bit ok, output logic [16:0] got);
    ok = 1'b0;
    got = 'x;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        got = {rsp_id, rsp_data};
      end else begin
        @(negedge clk);
      end
    end
  endtask

  function automatic logic [16:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_flags = 3'b000;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_tests++; if (rsp_data !== 16'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got=%b/%h exp=0/0000", rsp_id, rsp_data); end
    n_tests++; if (flags_q !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags_q); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_tests++; if (alu_in1 !== 16'h0 || alu_in2 !== 16'h0 || alu_op !== 4'h0) begin n_fail++; $display("FAIL reset_alu_drive got=%h/%h/%h exp=0/0/0", alu_in1, alu_in2, alu_op); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_flags = 3'b000;
  endtask

  task automatic test_basic_add();
    bit ok;
    logic [16:0] e;
    @(negedge clk);
    rsp_ready = 1'b1;
    send(1'b0, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL add_accept got=timeout exp=accept"); end
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || dbg_state !== ST_EXEC) begin n_fail++; $display("FAIL add_exec got=valid%b/state%0d exp=valid0/state1", rsp_valid, dbg_state); end
    n_tests++; if (alu_in1 !== 16'h7FFF || alu_in2 !== 16'h0001 || alu_op !== OP_ADD) begin n_fail++; $display("FAIL add_alu_drive got=%h/%h/%h exp=7fff/0001/0", alu_in1, alu_in2, alu_op); end
    @(negedge clk); #1;
    e = pop_exp();
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency got=valid%b exp=valid1 at T+2", rsp_valid); end
    n_tests++; if ({rsp_id, rsp_data} !== e || rsp_data !== 16'h8000) begin n_fail++; $display("FAIL add_data got=%b/%h exp=0/8000", rsp_id, rsp_data); end
    n_tests++; if (flags_q !== 3'b011 || flags_q !== mdl_flags) begin n_fail++; $display("FAIL add_flags got=%b exp=011", flags_q); end
    @(negedge clk); #1;
    n_tests++; if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_release got=state%0d/valid%b exp=state0/valid0", dbg_state, rsp_valid); end
  endtask

  task automatic test_masked_flags();
    bit ok;
    logic [16:0] e, got;
    @(negedge clk);
    rsp_ready = 1'b1;
    send(1'b0, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, ok);
    collect(ok, got);
    e = pop_exp();
    n_tests++; if (flags_q !== 3'b011) begin n_fail++; $display("FAIL mask_preload got=%b exp=011", flags_q); end
    @(negedge clk);
    send(1'b1, OP_XOR, 16'h00A5, 16'h00A5, 1'b1, ok);
    collect(ok, got);
    e = pop_exp();
    n_tests++; if (!ok || got !== e || got !== 17'h10000) begin n_fail++; $display("FAIL mask_rsp got=%h exp=%h", got, 17'h10000); end
    n_tests++; if (flags_q !== 3'b111 || flags_q !== mdl_flags) begin n_fail++; $display("FAIL mask_flags got=%b exp=111", flags_q); end
    @(negedge clk);
  endtask

  task automatic test_no_setflags();
    bit ok;
    logic [16:0] e, got;
    logic [2:0] prev;
    prev = mdl_flags;
    @(negedge clk);
    rsp_ready = 1'b1;
    send(1'b0, OP_SUB, 16'h0001, 16'h0002, 1'b0, ok);
    collect(ok, got);
    e = pop_exp();
    n_tests++; if (!ok || got !== e || got !== 17'h0FFFF) begin n_fail++; $display("FAIL nosf_rsp got=%h exp=0ffff", got); end
    n_tests++; if (flags_q !== prev) begin n_fail++; $display("FAIL nosf_flags got=%b exp=%b", flags_q, prev); end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int g;
    bit seq[3];
    bit exp_seq[3];
`ifdef ALU_ISSUE_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    rsp_ready = 1'b1;
    req0_op = OP_ADD; req0_a = 16'h0011; req0_b = 16'h0; req0_setflags = 1'b0;
    req1_op = OP_ADD; req1_a = 16'h0022; req1_b = 16'h0; req1_setflags = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    g = 0;
    for (int c = 0; c < 40 && g < 3; c++) begin
      #1;
      if (req0_ready && req1_ready) begin
        n_tests++; n_fail++; $display("FAIL simul_both_ready got=11 exp=one-hot");
      end else if (req0_ready || req1_ready) begin
        seq[g] = req1_ready;
        g++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++; if (g != 3) begin n_fail++; $display("FAIL simul_grant_count got=%0d exp=3", g); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (seq[k] !== exp_seq[k]) begin n_fail++; $display("FAIL simul_grant%0d got=%b exp=%b", k, seq[k], exp_seq[k]); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [16:0] e, got;
    bit exp_win;
`ifdef ALU_ISSUE_ARB_RR_EN
    exp_win = 1'b1;
`else
    exp_win = 1'b0;
`endif
    @(negedge clk);
    rsp_ready = 1'b0;
    send(1'b0, OP_ADD, 16'h1234, 16'h1111, 1'b0, ok);
    req0_valid = 1'b1; req1_valid = 1'b1;
    collect(ok, got);
    e = pop_exp();
    n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL bp_rsp got=%h exp=%h", got, e); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e) begin n_fail++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, rsp_valid, {rsp_id, rsp_data}, e); end
      n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got=%b%b exp=00", k, req0_ready, req1_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=state%0d/valid%b exp=state0/valid0", dbg_state, rsp_valid); end
    n_tests++; if (req1_ready !== exp_win || req0_ready !== !exp_win) begin n_fail++; $display("FAIL bp_next_grant got=%b%b exp=%b%b", req1_ready, req0_ready, exp_win, !exp_win); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [16:0] got;
    int seen;
    @(negedge clk);
    rsp_ready = 1'b1;
    send(1'b0, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, ok);
    collect(ok, got);
    void'(pop_exp());
    @(negedge clk);
    send(1'b1, OP_SUB, 16'h0000, 16'h0001, 1'b1, ok);
    rst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0 || flags_q !== 3'b000 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid got=valid%b/flags%b/state%0d exp=0/000/0", rsp_valid, flags_q, dbg_state); end
    rst = 1'b0;
    exp_q.delete();
    mdl_flags = 3'b000;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_rsp got=%0d responses exp=0", seen); end
  endtask

  task automatic test_random();
    bit ok, done;
    bit id, sf;
    logic [3:0] op;
    logic [15:0] a, b;
    logic [16:0] e;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      id = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      sf = 1'($urandom_range(0, 1));
      send(id, op, a, b, sf, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_accept got=timeout exp=accept", n); end
      #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_early got=valid1 exp=valid0", n); end
      @(negedge clk); #1;
      e = pop_exp();
      n_tests++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e) begin n_fail++; $display("FAIL rnd%0d_rsp got=%b/%h exp=1/%h", n, rsp_valid, {rsp_id, rsp_data}, e); end
      n_tests++; if (flags_q !== mdl_flags) begin n_fail++; $display("FAIL rnd%0d_flags got=%b exp=%b", n, flags_q, mdl_flags); end
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
        rsp_ready = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        done = rsp_ready;
        @(negedge clk); #1;
        if (!done) begin
          n_tests++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e) begin n_fail++; $display("FAIL rnd%0d_hold got=%b/%h exp=1/%h", n, rsp_valid, {rsp_id, rsp_data}, e); end
        end
      end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_release got=valid1 exp=valid0", n); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_masked_flags();
    test_no_setflags();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
